// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over a window of
// GATE_CYCLES system clocks and reports the count, with saturation and continuous mode.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 50000000,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned GATE_W      = 32
) (
  input  logic             in_50MHz,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic [CNT_W-1:0] freq_out,
  output logic             valid,
  output logic             busy,
  output logic             overflow
);

  typedef enum logic [1:0] {StIdle, StGate, StDone} state_e;

  localparam logic [GATE_W-1:0] GateLast = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CntMax   = '1;

  state_e            state_q, state_d;
  logic              s1_q, s2_q, s3_q;
  logic              edge_det;
  logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]  freq_q, freq_d;
  logic              sat_q, sat_d;
  logic              ovf_q, ovf_d;
  logic              valid_q, valid_d;

  // Synchronizer runs in every state so the first gate cycle sees valid history.
  always_ff @(posedge in_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_det = s2_q & ~s3_q;

  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    freq_d     = freq_q;
    sat_d      = sat_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start || cont) begin
          state_d    = StGate;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
        end
      end
      StGate: begin
        gate_cnt_d = gate_cnt_q + GATE_W'(1);
        if (edge_det) begin
          if (edge_cnt_q == CntMax) begin
            sat_d = 1'b1;
          end else begin
            edge_cnt_d = edge_cnt_q + CNT_W'(1);
          end
        end
        if (gate_cnt_q == GateLast) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // Result registers and valid update together, one cycle after this state.
        freq_d  = edge_cnt_q;
        ovf_d   = sat_q;
        valid_d = 1'b1;
        if (cont) begin
          state_d    = StGate;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge in_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      freq_q     <= '0;
      sat_q      <= 1'b0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      freq_q     <= freq_d;
      sat_q      <= sat_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
    end
  end

  assign freq_out = freq_q;
  assign overflow = ovf_q;
  assign valid    = valid_q;
  // In continuous mode the DONE gap still counts as busy.
  assign busy     = (state_q == StGate) || ((state_q == StDone) && cont);

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: records sig_in per clock and predicts each gate's count by
// counting rising transitions in the window of samples the gate covers.
module tb_freq_meter;

  localparam int GC = 1000;
  localparam int CW = 8;
  localparam int GW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          sig_in = 1'b0;
  logic          start = 1'b0;
  logic          cont = 1'b0;
  logic [CW-1:0] freq_out;
  logic          valid, busy, overflow;

  freq_meter #(
    .GATE_CYCLES(GC),
    .CNT_W      (CW),
    .GATE_W     (GW)
  ) dut (
    .in_50MHz(clk),
    .rst_n   (rst_n),
    .sig_in  (sig_in),
    .start   (start),
    .cont    (cont),
    .freq_out(freq_out),
    .valid   (valid),
    .busy    (busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  bit smp [0:65535];

  // smp[k] is sig_in as seen by the DUT at rising edge number k.
  always @(posedge clk) begin
    if (cyc < 65536) smp[cyc] <= sig_in;
    cyc <= cyc + 1;
  end

  int kind = 0, per = 2, ph = 0, prob = 0, p0 = -10, p1 = -10, p2 = -10;

  always @(negedge clk) begin
    case (kind)
      1: sig_in = (((cyc + ph) % per) < per / 2) ? 1'b1 : 1'b0;
      2: sig_in = ($urandom_range(0, 99) < prob) ? 1'b1 : 1'b0;
      3: sig_in = (cyc == p0 || cyc == p1 || cyc == p2) ? 1'b1 : 1'b0;
      4: sig_in = 1'b1;
      default: sig_in = 1'b0;
    endcase
  end

  int nvec = 0, nfail = 0;

  task automatic chk(input string name, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int got, input int lo, input int hi);
    nvec++;
    if (got < lo || got > hi) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  // Raw rising-edge count for a gate whose start was sampled at edge t.
  function automatic int model_raw(input int t);
    int c = 0;
    for (int m = t - 1; m <= t + GC - 2; m++) if (smp[m] && !smp[m-1]) c++;
    return c;
  endfunction

  function automatic int model_freq(input int t);
    int c = model_raw(t);
    return (c > 255) ? 255 : c;
  endfunction

  function automatic int model_ovf(input int t);
    return (model_raw(t) > 255) ? 1 : 0;
  endfunction

  task automatic wait_cyc(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic wait_valid(input int budget, output bit got, output int bhi, output int blo);
    got = 0; bhi = 0; blo = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (valid) got = 1;
      else if (busy) bhi++;
      else blo++;
    end
  endtask

  task automatic check_gate(input string nm, input int t, input bit got);
    chk({nm, "_valid_seen"}, int'(got), 1);
    chk({nm, "_valid_time"}, cyc, t + GC + 2);
    chk({nm, "_freq"}, int'(freq_out), model_freq(t));
    chk({nm, "_ovf"}, int'(overflow), model_ovf(t));
  endtask

  typedef struct packed {
    int kind; int per; int o0; int o1; int o2; int lo; int hi; int ovf;
  } vec_t;

  vec_t tbl [6];

  initial begin
    bit got;
    int bhi, blo, t, nv, vt;
    string nm;

    tbl[0] = '{1, 20,  0,   0,  0,  49,  51, 0};  // 50 edges +-1
    tbl[1] = '{1, 2,   0,   0,  0, 255, 255, 1};  // 500 edges saturate
    tbl[2] = '{1, 100, 0,   0,  0,  10,  10, 0};  // overflow must clear
    tbl[3] = '{3, 0,  -3,  -1, 998,  2,   2, 0};  // edges at gate_cnt 0 and 999
    tbl[4] = '{3, 0,  -1, 999,  -1,  1,   1, 0};  // edge in DONE excluded
    tbl[5] = '{4, 0,   0,   0,  0,   0,   0, 0};  // already-high level: no edge

    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_freq", int'(freq_out), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(overflow), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      nm = $sformatf("vec%0d", i);
      t = cyc + 8;
      kind = tbl[i].kind;
      if (tbl[i].kind == 1) begin
        per = tbl[i].per;
        ph = $urandom_range(0, tbl[i].per - 1);
      end
      p0 = t + tbl[i].o0; p1 = t + tbl[i].o1; p2 = t + tbl[i].o2;
      wait_cyc(t);
      start = 1'b1;
      wait_valid(1200, got, bhi, blo);
      check_gate(nm, t, got);
      chk_rng({nm, "_spec_freq"}, int'(freq_out), tbl[i].lo, tbl[i].hi);
      chk({nm, "_spec_ovf"}, int'(overflow), tbl[i].ovf);
      chk({nm, "_busy_len"}, bhi, GC);
      @(negedge clk);
      chk({nm, "_valid_1cyc"}, int'(valid), 0);
      chk({nm, "_idle_busy"}, int'(busy), 0);
    end

    for (int i = 0; i < 4; i++) begin
      nm = $sformatf("rnd%0d", i);
      kind = 2;
      prob = $urandom_range(5, 60);
      t = cyc + 8;
      wait_cyc(t);
      start = 1'b1;
      wait_valid(1200, got, bhi, blo);
      check_gate(nm, t, got);
    end

    // Continuous mode: back-to-back gates every GC+1 cycles, then drop cont mid-gate.
    @(negedge clk);
    kind = 1; per = 40; ph = $urandom_range(0, 39);
    t = cyc + 8;
    wait_cyc(t);
    cont = 1'b1;
    for (int k = 0; k < 3; k++) begin
      nm = $sformatf("cont%0d", k);
      wait_valid(1200, got, bhi, blo);
      check_gate(nm, t, got);
      chk_rng({nm, "_spec_freq"}, int'(freq_out), 24, 26);
      chk({nm, "_busy_gap"}, blo, 0);
      t = t + GC + 1;
    end
    wait_cyc(t + 300);
    cont = 1'b0;
    nv = 0; vt = 0;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if (valid) begin
        nv++;
        if (nv == 1) begin
          vt = cyc;
          chk("cont_drop_freq", int'(freq_out), model_freq(t));
        end
      end
    end
    chk("cont_drop_nvalid", nv, 1);
    chk("cont_drop_time", vt, t + GC + 2);
    chk("cont_drop_idle", int'(busy), 0);

    // start while busy must not queue a second gate.
    t = cyc + 8;
    wait_cyc(t);
    start = 1'b1;
    nv = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = (cyc == t + 100 || cyc == t + 500 || cyc == t + 1000 || cyc == t + 1001);
      if (valid) nv++;
    end
    start = 1'b0;
    chk("busy_start_nvalid", nv, 1);
    chk("busy_start_freq", int'(freq_out), model_freq(t));

    // Reset at gate_cnt=500 aborts with no valid.
    t = cyc + 8;
    wait_cyc(t);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(t + 501);
    chk("abort_busy_before", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_freq", int'(freq_out), 0);
    chk("abort_valid", int'(valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ovf", int'(overflow), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (valid) nv++;
    end
    chk("abort_nvalid", nv, 0);

    kind = 1; per = 20; ph = $urandom_range(0, 19);
    t = cyc + 8;
    wait_cyc(t);
    start = 1'b1;
    wait_valid(1200, got, bhi, blo);
    check_gate("post_rst", t, got);
    chk_rng("post_rst_spec_freq", int'(freq_out), 49, 51);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
